// File: rtl/cpu_pkg.sv
// Shared CPU phase definitions, used by the sequencer and by PC/decoder benches for phase tracing.
package cpu_pkg;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    EXEC1  = 2'd1,
    EXEC2  = 2'd2,
    HALTED = 2'd3
  } cpu_state_t;

endpackage

// File: rtl/stall_watchdog.sv
// Counts consecutive stall cycles spent in one sequencer state and flags a timeout
// on the last permitted stall cycle.
module stall_watchdog #(
  parameter int CNT_W         = 16,
  parameter int STALL_TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic stall,
  input  logic state_change,
  output logic timeout
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STALL_TIMEOUT - 1);

  logic [CNT_W-1:0] stall_cnt;

  // Saturating counter so a stuck stall can never wrap back below the limit
  always_ff @(posedge clk) begin
    if (reset || state_change) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign timeout = stall && (stall_cnt == LIMIT);

endmodule

// File: rtl/cpu_sequencer.sv
// Multicycle FETCH/EXEC1/EXEC2 control FSM with Avalon-style memory handshake,
// ALU-busy stalling and a stall watchdog that forces a sticky halt.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int STALL_TIMEOUT = 255,
  parameter int CNT_W         = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic mem_waitrequest,
  input  logic pc_halt,
  input  logic exec1_load,
  input  logic exec1_store,
  input  logic alu_busy,
  output logic fetch,
  output logic exec1,
  output logic exec2,
  output logic ir_write_en,
  output logic mem_read,
  output logic mem_write,
  output logic active,
  output logic timeout_err
);

  cpu_state_t state;
  cpu_state_t base_next;
  cpu_state_t next_state;
  logic       stall;
  logic       timeout;
  logic       state_change;

  // A stall is any cycle the FSM holds its state purely because memory or the ALU is not done
  always_comb begin
    stall = 1'b0;
    case (state)
      FETCH:   stall = !pc_halt && mem_waitrequest;
      EXEC1:   stall = (exec1_load || exec1_store) && mem_waitrequest;
      EXEC2:   stall = alu_busy;
      default: stall = 1'b0;
    endcase
  end

  always_comb begin
    base_next   = state;
    fetch       = 1'b0;
    exec1       = 1'b0;
    exec2       = 1'b0;
    ir_write_en = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    active      = 1'b1;
    case (state)
      FETCH: begin
        if (pc_halt) begin
          base_next = HALTED;
        end else begin
          mem_read = 1'b1;
          if (!mem_waitrequest) begin
            fetch       = 1'b1;
            ir_write_en = 1'b1;
            base_next   = EXEC1;
          end
        end
      end
      EXEC1: begin
        exec1     = 1'b1;
        mem_write = exec1_store;
        mem_read  = exec1_load && !exec1_store;
        if (!stall) begin
          base_next = EXEC2;
        end
      end
      EXEC2: begin
        exec2 = 1'b1;
        if (!alu_busy) begin
          base_next = FETCH;
        end
      end
      default: begin
        active = 1'b0;
      end
    endcase
  end

  assign next_state   = timeout ? HALTED : base_next;
  assign state_change = (next_state != state);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= FETCH;
      timeout_err <= 1'b0;
    end else begin
      state <= next_state;
      if (timeout) begin
        timeout_err <= 1'b1;
      end
    end
  end

  stall_watchdog #(
    .CNT_W         (CNT_W),
    .STALL_TIMEOUT (STALL_TIMEOUT)
  ) u_watchdog (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .state_change (state_change),
    .timeout      (timeout)
  );

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed self-checking bench for cpu_sequencer with a short stall timeout of 8 cycles.
module tb_cpu_sequencer;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic mem_waitrequest;
  logic pc_halt;
  logic exec1_load;
  logic exec1_store;
  logic alu_busy;
  logic fetch;
  logic exec1;
  logic exec2;
  logic ir_write_en;
  logic mem_read;
  logic mem_write;
  logic active;
  logic timeout_err;

  int checks = 0;
  int errors = 0;

  // Expected output patterns, bit order {fetch, exec1, exec2, ir_write_en, mem_read, mem_write, active, timeout_err}
  localparam logic [7:0] F_GO    = 8'b1001_1010;
  localparam logic [7:0] F_WAIT  = 8'b0000_1010;
  localparam logic [7:0] F_HREQ  = 8'b0000_0010;
  localparam logic [7:0] E1_IDLE = 8'b0100_0010;
  localparam logic [7:0] E1_RD   = 8'b0100_1010;
  localparam logic [7:0] E1_WR   = 8'b0100_0110;
  localparam logic [7:0] E2      = 8'b0010_0010;
  localparam logic [7:0] HALT    = 8'b0000_0000;
  localparam logic [7:0] HALT_TO = 8'b0000_0001;

  cpu_sequencer #(
    .STALL_TIMEOUT (8),
    .CNT_W         (16)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .mem_waitrequest (mem_waitrequest),
    .pc_halt         (pc_halt),
    .exec1_load      (exec1_load),
    .exec1_store     (exec1_store),
    .alu_busy        (alu_busy),
    .fetch           (fetch),
    .exec1           (exec1),
    .exec2           (exec2),
    .ir_write_en     (ir_write_en),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .active          (active),
    .timeout_err     (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic wr, input logic halt, input logic ld, input logic st, input logic busy);
    mem_waitrequest = wr;
    pc_halt         = halt;
    exec1_load      = ld;
    exec1_store     = st;
    alu_busy        = busy;
  endtask

  // Check this cycle's outputs after inputs settle, then advance to just past the next edge
  task automatic cycleCheck(input string tag, input logic [7:0] expected);
    #1;
    checkOutput(tag, {8'h00, fetch, exec1, exec2, ir_write_en, mem_read, mem_write, active, timeout_err},
                {8'h00, expected});
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    cycleCheck("reset_state", F_WAIT);
    reset = 1'b0;

    $display("[TB] test 1: back-to-back plain instructions");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      cycleCheck("t1_fetch", F_GO);
      cycleCheck("t1_exec1", E1_IDLE);
      cycleCheck("t1_exec2", E2);
    end

    $display("[TB] test 2: fetch waitrequest for 3 cycles");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycleCheck("t2_fetch_wait", F_WAIT);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycleCheck("t2_fetch_go", F_GO);
    cycleCheck("t2_exec1", E1_IDLE);
    cycleCheck("t2_exec2", E2);

    $display("[TB] load instruction");
    cycleCheck("ld_fetch", F_GO);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    cycleCheck("ld_exec1_wait", E1_RD);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cycleCheck("ld_exec1_go", E1_RD);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycleCheck("ld_exec2", E2);

    $display("[TB] test 4: store stall then ALU busy");
    cycleCheck("t4_fetch", F_GO);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) cycleCheck("t4_store_wait", E1_WR);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    cycleCheck("t4_store_go", E1_WR);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) cycleCheck("t4_alu_busy", E2);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycleCheck("t4_alu_done", E2);

    $display("[TB] stalls of 7 cycles in two states stay below the timeout");
    cycleCheck("s7_fetch", F_GO);
    cycleCheck("s7_exec1", E1_IDLE);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) cycleCheck("s7_alu_busy", E2);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycleCheck("s7_alu_done", E2);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) cycleCheck("s7_fetch_wait", F_WAIT);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycleCheck("s7_fetch_go", F_GO);
    cycleCheck("s7_exec1_b", E1_IDLE);
    cycleCheck("s7_exec2_b", E2);

    $display("[TB] test 6: reset during EXEC1 store stall");
    cycleCheck("t6_fetch", F_GO);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    cycleCheck("t6_store_wait0", E1_WR);
    cycleCheck("t6_store_wait1", E1_WR);
    checkOutput("t6_cnt_before", dut.u_watchdog.stall_cnt, 16'd2);
    reset = 1'b1;
    cycleCheck("t6_store_wait2", E1_WR);
    checkOutput("t6_cnt_cleared", dut.u_watchdog.stall_cnt, 16'd0);
    cycleCheck("t6_after_reset", F_WAIT);
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycleCheck("t6_fetch_go", F_GO);
    cycleCheck("t6_exec1", E1_IDLE);
    cycleCheck("t6_exec2", E2);

    $display("[TB] test 5: stuck waitrequest triggers timeout");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) cycleCheck("t5_fetch_wait", F_WAIT);
    cycleCheck("t5_halted", HALT_TO);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycleCheck("t5_halted_stays", HALT_TO);
    reset = 1'b1;
    @(posedge clk);
    #1;
    cycleCheck("t5_reset_clears", F_GO);
    reset = 1'b0;
    cycleCheck("t5_restart_fetch", F_GO);
    cycleCheck("t5_restart_exec1", E1_IDLE);
    cycleCheck("t5_restart_exec2", E2);

    $display("[TB] test 3: pc_halt in FETCH beats waitrequest");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cycleCheck("t3_halt_req", F_HREQ);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) cycleCheck("t3_halted", HALT);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
